// File: rtl/hit_resolver_if.sv
// Player-geometry/state bundle into the hit resolver and the stun/health results back out.
interface hit_resolver_if #(
  parameter int POS_W = 10,
  parameter int HP_W  = 7
);
  logic             frame_tick;
  logic [POS_W-1:0] x1, x2;
  logic [3:0]       state1, state2;
  logic [1:0]       p1_stunmode, p2_stunmode;
  logic             p1_hit_pulse, p2_hit_pulse;
  logic [HP_W-1:0]  p1_health, p2_health;
  logic             game_over;

  modport master (
    output frame_tick, x1, x2, state1, state2,
    input  p1_stunmode, p2_stunmode, p1_hit_pulse, p2_hit_pulse,
           p1_health, p2_health, game_over
  );
  modport slave (
    input  frame_tick, x1, x2, state1, state2,
    output p1_stunmode, p2_stunmode, p1_hit_pulse, p2_hit_pulse,
           p1_health, p2_health, game_over
  );
endinterface

// File: rtl/hit_resolver.sv
// Per-frame hitbox/hurtbox resolution, stun timers and saturating health for two players.
// Define CHIP_DAMAGE_EN to make blocked hits cost max(1, dmg>>2) health.
module hit_resolver #(
  parameter int POS_W        = 10,
  parameter int BASE_W       = 64,
  parameter int NEUTRAL_HB_W = 30,
  parameter int DIR_HB_W     = 48,
  parameter int HITSTUN_FR   = 12,
  parameter int BLOCKSTUN_FR = 6,
  parameter int HEALTH_MAX   = 100,
  parameter int NEUTRAL_DMG  = 10,
  parameter int DIR_DMG      = 15,
  parameter int CNT_W        = 5,
  parameter int HP_W         = 7
) (
  input  logic          clk,
  input  logic          rst,
  hit_resolver_if.slave hr
);
  localparam int GW = POS_W + 1;
  typedef enum logic [1:0] {M_NEUT = 2'b00, M_HIT = 2'b01, M_BLK = 2'b10, M_WHIFF = 2'b11} mode_e;

  logic [1:0][3:0]       st;
  logic [1:0][GW-1:0]    xg, w;
  logic [1:0]            act, rec, dir, conn, struck, blocked, reach;
  logic [1:0][HP_W-1:0]  dmg, hp_q, hp_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  mode_e [1:0]           mode_q, mode_d;
  logic [1:0]            cons_q, cons_d, lcons_q, lcons_d, pulse_q, pulse_d;
  logic                  go_q, go_d, eval, trade;
  logic [GW-1:0]         p1_reach, p1_right, p2_minus, p2_left;
  logic [HP_W-1:0]       chip, hdmg;

  assign st = {hr.state2, hr.state1};
  assign xg = {{1'b0, hr.x2}, {1'b0, hr.x1}};

  always_comb begin
    eval = hr.frame_tick && !go_q;
    for (int i = 0; i < 2; i++) begin
      act[i] = (st[i] == 4'd4) || (st[i] == 4'd7);
      rec[i] = (st[i] == 4'd5) || (st[i] == 4'd8);
      dir[i] = (st[i] >= 4'd6) && (st[i] <= 4'd8);
      w[i]   = dir[i] ? GW'(DIR_HB_W) : GW'(NEUTRAL_HB_W);
      dmg[i] = dir[i] ? HP_W'(DIR_DMG) : HP_W'(NEUTRAL_DMG);
    end
    // P2 extends leftwards, so its edge is clamped at 0 instead of wrapping
    p1_reach = xg[0] + GW'(BASE_W) + w[0];
    p1_right = xg[0] + GW'(BASE_W) + (rec[0] ? w[0] : '0);
    p2_minus = (xg[1] >= w[1]) ? xg[1] - w[1] : '0;
    p2_left  = rec[1] ? p2_minus : xg[1];
    reach[0] = p1_reach > p2_left;
    reach[1] = p2_minus < p1_right;
    for (int i = 0; i < 2; i++) conn[i] = eval && act[i] && !cons_q[i] && reach[i];
    trade = conn[0] && conn[1];
    go_d  = go_q;
    chip  = '0;
    hdmg  = '0;
    for (int v = 0; v < 2; v++) begin
      struck[v]  = conn[1-v];
      blocked[v] = struck[v] && !trade && (st[v] == 4'd2);
`ifdef CHIP_DAMAGE_EN
      chip = ((dmg[1-v] >> 2) == '0) ? HP_W'(1) : (dmg[1-v] >> 2);
`else
      chip = '0;
`endif
      hdmg     = blocked[v] ? chip : dmg[1-v];
      hp_d[v]  = !struck[v] ? hp_q[v] : (hp_q[v] > hdmg) ? hp_q[v] - hdmg : '0;
      pulse_d[v] = struck[v];
      cnt_d[v] = struck[v] ? (blocked[v] ? CNT_W'(BLOCKSTUN_FR) : CNT_W'(HITSTUN_FR))
               : (eval && cnt_q[v] != '0) ? cnt_q[v] - 1'b1 : cnt_q[v];
      cons_d[v]  = !eval ? cons_q[v] : conn[v] ? 1'b1 : act[v] ? cons_q[v] : 1'b0;
      // remembers whether the last active window connected, for whiff detection in recovery
      lcons_d[v] = (eval && act[v]) ? cons_d[v] : lcons_q[v];
      mode_d[v]  = mode_q[v];
      if (struck[v])               mode_d[v] = blocked[v] ? M_BLK : M_HIT;
      else if (eval && cnt_d[v] == '0) mode_d[v] = (rec[v] && !lcons_q[v]) ? M_WHIFF : M_NEUT;
      if (hp_d[v] == '0) go_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hp_q    <= {2{HP_W'(HEALTH_MAX)}};
      cnt_q   <= '0;
      mode_q  <= {M_NEUT, M_NEUT};
      cons_q  <= '0;
      lcons_q <= '0;
      pulse_q <= '0;
      go_q    <= 1'b0;
    end else begin
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cons_q  <= cons_d;
      lcons_q <= lcons_d;
      pulse_q <= pulse_d;
      go_q    <= go_d;
    end
  end

  assign hr.p1_stunmode  = mode_q[0];
  assign hr.p2_stunmode  = mode_q[1];
  assign hr.p1_hit_pulse = pulse_q[0];
  assign hr.p2_hit_pulse = pulse_q[1];
  assign hr.p1_health    = hp_q[0];
  assign hr.p2_health    = hp_q[1];
  assign hr.game_over    = go_q;
endmodule

// File: tb/tb_hit_resolver.sv
// Directed checks of hit_resolver against hand-computed stun/health values.
module tb_hit_resolver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   p1_pc = 0;
  int   p2_pc = 0;
  int   pc0;

  hit_resolver_if #(.POS_W(10), .HP_W(7)) hr ();
  hit_resolver dut (.clk(clk), .rst(rst), .hr(hr.slave));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hr.p1_hit_pulse === 1'b1) p1_pc++;
    if (hr.p2_hit_pulse === 1'b1) p2_pc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    hr.frame_tick = 1'b1;
    @(negedge clk);
    hr.frame_tick = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic setup(input int a, input int b, input int s1, input int s2);
    hr.x1 = 10'(a); hr.x2 = 10'(b);
    hr.state1 = 4'(s1); hr.state2 = 4'(s2);
  endtask

  task automatic hit(input int s);
    hr.state1 = 4'(s); tick();
    hr.state1 = 4'd1;  tick();
  endtask

  initial begin
    hr.frame_tick = 1'b0;
    setup(100, 190, 1, 1);
    reset_dut();
    chk("rst_p1mode", hr.p1_stunmode, 0);
    chk("rst_p2mode", hr.p2_stunmode, 0);
    chk("rst_p1hp", hr.p1_health, 100);
    chk("rst_p2hp", hr.p2_health, 100);
    chk("rst_go", hr.game_over, 0);
    chk("rst_pulse", {hr.p1_hit_pulse, hr.p2_hit_pulse}, 0);

    // neutral hit, 12-tick hitstun
    setup(100, 190, 4, 1);
    pc0 = p2_pc;
    tick();
    chk("t1_mode", hr.p2_stunmode, 1);
    chk("t1_hp", hr.p2_health, 90);
    chk("t1_pulse", hr.p2_hit_pulse, 1);
    for (int i = 0; i < 11; i++) tick();
    chk("t1_mode_11", hr.p2_stunmode, 1);
    tick();
    chk("t1_mode_12", hr.p2_stunmode, 0);
    chk("t1_npulse", p2_pc - pc0, 1);

    // one hit per activation
    reset_dut();
    setup(100, 190, 4, 1);
    pc0 = p2_pc;
    for (int i = 0; i < 5; i++) tick();
    chk("t2_hp", hr.p2_health, 90);
    chk("t2_npulse", p2_pc - pc0, 1);
    chk("t2_p1hp", hr.p1_health, 100);

    // directional hit into block
    reset_dut();
    setup(100, 200, 7, 2);
    tick();
    chk("t3_mode", hr.p2_stunmode, 2);
`ifdef CHIP_DAMAGE_EN
    chk("t3_hp", hr.p2_health, 97);
`else
    chk("t3_hp", hr.p2_health, 100);
`endif
    chk("t3_pulse", hr.p2_hit_pulse, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("t3_mode_5", hr.p2_stunmode, 2);
    tick();
    chk("t3_mode_6", hr.p2_stunmode, 0);

    // whiff
    reset_dut();
    setup(100, 300, 4, 1);
    tick();
    chk("t4_p2mode", hr.p2_stunmode, 0);
    chk("t4_p1mode_act", hr.p1_stunmode, 0);
    hr.state1 = 4'd5;
    tick();
    chk("t4_p1whiff", hr.p1_stunmode, 3);
    chk("t4_hp", hr.p2_health, 100);
    hr.state1 = 4'd1;
    tick();
    chk("t4_p1neut", hr.p1_stunmode, 0);

    // trade
    reset_dut();
    setup(100, 180, 4, 4);
    tick();
    chk("t5_p1mode", hr.p1_stunmode, 1);
    chk("t5_p2mode", hr.p2_stunmode, 1);
    chk("t5_p1hp", hr.p1_health, 90);
    chk("t5_p2hp", hr.p2_health, 90);
    chk("t5_pulses", {hr.p1_hit_pulse, hr.p2_hit_pulse}, 3);

    // reach boundary: 100+64+30 = 194 must strictly exceed x2
    reset_dut();
    setup(100, 194, 4, 1);
    tick();
    chk("t7_nohit_hp", hr.p2_health, 100);
    chk("t7_nohit_mode", hr.p2_stunmode, 0);
    reset_dut();
    setup(100, 193, 4, 1);
    tick();
    chk("t7_hit_hp", hr.p2_health, 90);

    // saturation, game over, freeze, reset
    reset_dut();
    setup(100, 190, 1, 1);
    for (int i = 0; i < 5; i++) hit(7);
    chk("t6_hp25", hr.p2_health, 25);
    hit(4);
    hit(4);
    chk("t6_hp5", hr.p2_health, 5);
    chk("t6_go0", hr.game_over, 0);
    hr.state1 = 4'd4;
    tick();
    chk("t6_hp0", hr.p2_health, 0);
    chk("t6_go1", hr.game_over, 1);
    hr.state1 = 4'd1; tick();
    hr.state1 = 4'd7;
    for (int i = 0; i < 14; i++) tick();
    chk("t6_go_sticky", hr.game_over, 1);
    chk("t6_hp_hold", hr.p2_health, 0);
    chk("t6_mode_frozen", hr.p2_stunmode, 1);
    chk("t6_p1hp", hr.p1_health, 100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_go", hr.game_over, 0);
    chk("t6_rst_p2hp", hr.p2_health, 100);
    chk("t6_rst_p2mode", hr.p2_stunmode, 0);
    chk("t6_rst_p1mode", hr.p1_stunmode, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
